// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Multi-channel LED driver. A shared prescaler produces a slow tick from clk,
// and a shared free-running counter provides the PWM ramp. Each channel runs
// one of four modes: OFF, ON, BLINK (half-period counted in ticks) or
// PWM (duty counted in clk cycles per frame). Channels are reprogrammed at
// runtime through a single valid/ready write port.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cfg_valid   write request
//   cfg_ready   write can be accepted this cycle (drops for one cycle after
//               every acceptance)
//   cfg_ch      target channel index
//   cfg_mode    0=OFF, 1=ON, 2=BLINK, 3=PWM
//   cfg_period  BLINK half-period in ticks (0 behaves as 1)
//   cfg_duty    PWM high count per frame
//   cfg_err     one-cycle pulse when an accepted write named a missing channel
//   tick        registered one-cycle pulse per prescaler wrap
//   led         registered LED drive, active high
module led_pattern_gen #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 4800,
    parameter int PER_W    = 16,
    parameter int PWM_W    = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic              tick,
    output logic [NUM_CH-1:0] led
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick_int;
    logic             accept;
    logic             ch_ok;

    mode_e            mode    [NUM_CH];
    logic [PER_W-1:0] period  [NUM_CH];
    logic [PWM_W-1:0] duty    [NUM_CH];
    logic [PER_W-1:0] ph_cnt  [NUM_CH];
    logic [PER_W-1:0] ph_last [NUM_CH];
    logic [NUM_CH-1:0] blink_q;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] led_nxt;

    assign tick_int = (pre_cnt == PRE_MAX);
    assign accept   = cfg_valid && cfg_ready;
    assign ch_ok    = ({1'b0, cfg_ch} < NUM_CH_V);

    always_comb begin
        wr_sel  = '0;
        led_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // An out-of-range index selects no channel at all.
            wr_sel[i]  = accept && ch_ok && (cfg_ch == CH_W'(i));
            // Period 0 is treated as period 1: the last phase is then 0.
            ph_last[i] = (period[i] == '0) ? '0 : period[i] - PER_W'(1);
            case (mode[i])
                MODE_OFF:   led_nxt[i] = 1'b0;
                MODE_ON:    led_nxt[i] = 1'b1;
                MODE_BLINK: led_nxt[i] = blink_q[i];
                MODE_PWM:   led_nxt[i] = (pwm_cnt < duty[i]);
                default:    led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            tick      <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            led       <= '0;
            blink_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode[i]   <= MODE_OFF;
                period[i] <= '0;
                duty[i]   <= '0;
                ph_cnt[i] <= '0;
            end
        end else begin
            pre_cnt   <= tick_int ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
            tick      <= tick_int;
            // Ready drops for exactly the cycle after an acceptance.
            cfg_ready <= !accept;
            cfg_err   <= accept && !ch_ok;
            led       <= led_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    // A write on a tick edge wins: the tick is dropped for
                    // this channel and BLINK restarts lit at phase 0.
                    mode[i]    <= mode_e'(cfg_mode);
                    period[i]  <= cfg_period;
                    duty[i]    <= cfg_duty;
                    ph_cnt[i]  <= '0;
                    blink_q[i] <= 1'b1;
                end else if (tick_int && (mode[i] == MODE_BLINK)) begin
                    if (ph_cnt[i] == ph_last[i]) begin
                        ph_cnt[i]  <= '0;
                        blink_q[i] <= ~blink_q[i];
                    end else begin
                        ph_cnt[i] <= ph_cnt[i] + PER_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (NUM_CH=3, TICK_DIV=4, PER_W=8, PWM_W=4).
// The reference model describes each channel by its last written config and
// the edge number of that write; LED values are derived from elapsed edges
// and tick counts with plain arithmetic.
module tb_led_pattern_gen;

    localparam int NCH = 3;
    localparam int TD  = 4;
    localparam int PW  = 8;
    localparam int MW  = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch = '0;
    logic [1:0]     cfg_mode = '0;
    logic [PW-1:0]  cfg_period = '0;
    logic [MW-1:0]  cfg_duty = '0;
    logic           cfg_err;
    logic           tick;
    logic [NCH-1:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: edges since reset release, and per-channel last write.
    int e = 0;
    bit m_ready = 1'b1;
    int m_mode [NCH];
    int m_per  [NCH];
    int m_duty [NCH];
    int m_w    [NCH];

    typedef struct {
        bit       v;
        int       ch;
        int       mode;
        bit       exp_ready;
        bit       exp_err;
        logic [2:0] exp_led;
    } vec_t;

    led_pattern_gen #(
        .NUM_CH(NCH), .TICK_DIV(TD), .PER_W(PW), .PWM_W(MW), .CH_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .cfg_err(cfg_err), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    // LED after edge edge_n, from the channel state held after edge edge_n-1.
    function automatic bit model_led(input int c, input int edge_n);
        int n;
        int p;
        case (m_mode[c])
            0: return 1'b0;
            1: return 1'b1;
            2: begin
                p = (m_per[c] == 0) ? 1 : m_per[c];
                // ticks land on edges that are multiples of TD
                n = (edge_n - 1) / TD - m_w[c] / TD;
                return ((n / p) % 2) == 0;
            end
            default: return ((edge_n - 1) % (1 << MW)) < m_duty[c];
        endcase
    endfunction

    task automatic step();
        logic [NCH-1:0] exp_led;
        bit acc;
        bit err;
        @(posedge clk);
        e++;
        for (int c = 0; c < NCH; c++) exp_led[c] = model_led(c, e);
        acc = cfg_valid && m_ready;
        err = acc && (int'(cfg_ch) >= NCH);
        if (acc && !err) begin
            m_mode[int'(cfg_ch)] = int'(cfg_mode);
            m_per[int'(cfg_ch)]  = int'(cfg_period);
            m_duty[int'(cfg_ch)] = int'(cfg_duty);
            m_w[int'(cfg_ch)]    = e;
        end
        m_ready = !acc;
        #1;
        check("led", 32'(led), 32'(exp_led));
        check("tick", 32'(tick), 32'((e % TD) == 0));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        check("cfg_err", 32'(cfg_err), 32'(err));
    endtask

    // Asserts reset at the current (non-edge) time and checks outputs
    // immediately, then on each held edge; releases on a falling edge.
    task automatic reset_dut(input int hold);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(1));
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_err", 32'(cfg_err), 32'(0));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("rst_hold_led", 32'(led), 32'(0));
            check("rst_hold_ready", 32'(cfg_ready), 32'(1));
            check("rst_hold_tick", 32'(tick), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        m_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_w[c] = 0;
        end
    endtask

    task automatic write_cfg(input int ch, input int mode, input int per, input int duty,
                             output int wa);
        cfg_valid = 1'b0;
        if (!m_ready) step();
        cfg_ch     = CW'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = PW'(per);
        cfg_duty   = MW'(duty);
        cfg_valid  = 1'b1;
        step();
        wa = e;
        cfg_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl[10];
        int   wa;
        int   hi;
        logic prev;
        int   chg[$];

        tbl[0] = '{1'b1, 0, 1, 1'b0, 1'b0, 3'b000};
        tbl[1] = '{1'b1, 1, 1, 1'b1, 1'b0, 3'b001};
        tbl[2] = '{1'b1, 1, 1, 1'b0, 1'b0, 3'b001};
        tbl[3] = '{1'b1, 3, 1, 1'b1, 1'b0, 3'b011};
        tbl[4] = '{1'b1, 3, 1, 1'b0, 1'b1, 3'b011};
        tbl[5] = '{1'b0, 0, 0, 1'b1, 1'b0, 3'b011};
        tbl[6] = '{1'b1, 0, 0, 1'b0, 1'b0, 3'b011};
        tbl[7] = '{1'b0, 0, 0, 1'b1, 1'b0, 3'b010};
        tbl[8] = '{1'b1, 2, 1, 1'b0, 1'b0, 3'b010};
        tbl[9] = '{1'b0, 0, 0, 1'b1, 1'b0, 3'b110};

        #2;
        // Reset defaults and tick cadence
        reset_dut(3);
        repeat (12) step();

        // Handshake / out-of-range table, from a fresh reset
        reset_dut(1);
        for (int i = 0; i < 10; i++) begin
            cfg_valid  = tbl[i].v;
            cfg_ch     = CW'(tbl[i].ch);
            cfg_mode   = 2'(tbl[i].mode);
            cfg_period = '0;
            cfg_duty   = '0;
            step();
            check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
        end
        cfg_valid = 1'b0;

        // BLINK ch1 period 3: lit right after acceptance, toggles every 12
        reset_dut(2);
        write_cfg(1, 2, 3, 0, wa);
        step();
        check("blink_first_lit", 32'(led[1]), 32'(1));
        prev = led[1];
        repeat (50) begin
            step();
            if (led[1] !== prev) begin
                chg.push_back(e);
                prev = led[1];
            end
        end
        check("blink_toggle_count", 32'(chg.size() >= 3), 32'(1));
        if (chg.size() >= 3) begin
            check("blink_interval_a", 32'(chg[1] - chg[0]), 32'(12));
            check("blink_interval_b", 32'(chg[2] - chg[1]), 32'(12));
        end
        check("blink_others_off", 32'({led[2], led[0]}), 32'(0));

        // PWM ch0: duty 5, 0, 15
        reset_dut(2);
        write_cfg(0, 3, 0, 5, wa);
        step();
        for (int f = 0; f < 2; f++) begin
            hi = 0;
            repeat (16) begin step(); hi += int'(led[0]); end
            check("pwm_duty5_frame", 32'(hi), 32'(5));
        end
        write_cfg(0, 3, 0, 0, wa);
        step();
        hi = 0;
        repeat (64) begin step(); hi += int'(led[0]); end
        check("pwm_duty0", 32'(hi), 32'(0));
        write_cfg(0, 3, 0, 15, wa);
        step();
        hi = 0;
        repeat (16) begin step(); hi += int'(led[0]); end
        check("pwm_duty15", 32'(hi), 32'(15));

        // Collision: BLINK rewrite of ch2 accepted on a tick edge
        reset_dut(2);
        write_cfg(0, 2, 1, 0, wa);
        write_cfg(2, 2, 5, 0, wa);
        for (int k = 0; k < 8 && !(((e % TD) == TD - 1) && m_ready); k++) step();
        cfg_ch = 2'd2; cfg_mode = 2'd2; cfg_period = PW'(2); cfg_duty = '0;
        cfg_valid = 1'b1;
        step();
        wa = e;
        cfg_valid = 1'b0;
        check("coll_on_tick_edge", 32'(tick), 32'(1));
        step();
        check("coll_ch2_lit", 32'(led[2]), 32'(1));
        repeat (6) step();
        step();
        check("coll_ch2_still_lit", 32'(led[2]), 32'(1));
        step();
        check("coll_ch2_toggled", 32'(led[2]), 32'(0));

        // Asynchronous reset mid-run with ch0 PWM, ch1 BLINK, ch2 ON
        reset_dut(2);
        write_cfg(0, 3, 0, 8, wa);
        write_cfg(1, 2, 4, 0, wa);
        write_cfg(2, 1, 0, 0, wa);
        step();
        check("prerst_ch1", 32'(led[1]), 32'(1));
        check("prerst_ch2", 32'(led[2]), 32'(1));
        reset_dut(3);
        repeat (20) step();
        check("postrst_all_off", 32'(led), 32'(0));

        // Randomized traffic against the model
        reset_dut(1);
        repeat (800) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = CW'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = PW'($urandom_range(0, 3));
            cfg_duty   = MW'($urandom_range(0, 15));
            step();
        end
        cfg_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel, parametrised LED driver that replaces the single fixed-rate blinker. A shared prescaler derives a slow tick from the system clock. Each of NUM_CH channels independently runs one of four modes: off, on, blink at a programmable period in ticks, or PWM dim at a programmable duty. Channels are configured at runtime through a single valid/ready write port. Outputs drive board LEDs directly.

## Interface
- NUM_CH, 4: number of LED channels, 1..16
- TICK_DIV, 4800: clk cycles per tick, ≥2
- PER_W, 16: width of the blink period field
- PWM_W, 8: width of the PWM counter and duty field
- CH_W, $clog2(NUM_CH) (minimum 1): width of the channel index
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cfg_valid  input  1  config write request
- cfg_ready  output  1  block can accept a write this cycle
- cfg_ch  input  CH_W  target channel
- cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
- cfg_period  input  PER_W  blink half-period in ticks
- cfg_duty  input  PWM_W  PWM high count
- cfg_err  output  1  one-cycle pulse: accepted write had cfg_ch ≥ NUM_CH
- tick  output  1  one-cycle pulse per prescaler wrap
- led  output  NUM_CH  registered LED drive, active high

## Operation
- Prescaler: pre_cnt counts 0..TICK_DIV-1 and wraps. The internal tick is asserted combinationally while pre_cnt == TICK_DIV-1. The tick output is a registered copy of the internal tick, one cycle later.
- PWM counter: PWM_W bits, shared by all channels. Increments every clk and wraps at 2^PWM_W-1 → 0.
- Per-channel state: mode, period, duty, ph_cnt (PER_W bits), blink_q.
- OFF: led=0.
- ON: led=1.
- BLINK: ph_cnt advances on each tick. When a tick arrives with ph_cnt == max(period,1)-1, ph_cnt is set to 0 and blink_q toggles. led=blink_q. A period of 0 behaves exactly like a period of 1.
- PWM: led = (pwm_cnt < duty). duty=0 gives a constant 0. duty=2^PWM_W-1 gives high for all but one cycle per PWM frame.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready is 0 for exactly the cycle after an acceptance, then returns to 1. Accepted writes are therefore at most one every two cycles.
  - The accepted write updates mode, period and duty of cfg_ch on the acceptance edge.
  - The same write clears that channel's ph_cnt to 0 and sets blink_q to 1, so BLINK starts lit.
- Out-of-range channel: the write is accepted, no channel state changes, and cfg_err pulses high for one cycle.
- Write and tick on the same edge for the same channel: the write wins. ph_cnt=0, blink_q=1, and the tick is ignored for that channel only. Other channels process the tick normally.
- Mode changes take effect at led on the next edge after acceptance. No glitch or partial update is permitted.
- Asynchronous reset mid-operation returns every register to its reset value immediately. Counting restarts from 0 on the first clk after rst_n deasserts.

## Timing
- Reset values:
  - led=0, tick=0, cfg_err=0, cfg_ready=1
  - pre_cnt=0, pwm_cnt=0
  - per channel: mode=OFF, period=0, duty=0, ph_cnt=0, blink_q=0
- tick: first pulse at the edge TICK_DIV cycles after reset release, then every TICK_DIV cycles.
- Acceptance at edge N:
  - led reflects the new config at edge N+1
  - cfg_ready=0 during cycle N..N+1
  - cfg_err, if applicable, is high during cycle N..N+1
- BLINK toggle rate: led toggles every max(period,1)×TICK_DIV cycles, 50% duty.
- PWM frame: 2^PWM_W clk cycles. High time is duty cycles per frame.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Arithmetic: all counters are unsigned and wrap modulo their width. pre_cnt is sized $clog2(TICK_DIV).

## Test plan
- Reset defaults: TICK_DIV=4, hold rst_n low for 3 cycles, then release.
  - During reset: led=0, cfg_ready=1, tick=0.
  - After release: first tick pulse 4 cycles later, then every 4 cycles.
- BLINK: write ch1 mode=2 period=3.
  - led[1]=1 the cycle after acceptance.
  - led[1] toggles every 12 cycles.
  - Other channels stay 0.
- PWM: PWM_W=4, write ch0 mode=3 duty=5.
  - led[0] high for exactly 5 of every 16 cycles, repeating.
  - duty=0 gives 0 for 64 cycles.
  - duty=15 gives 15/16 high.
- Handshake and error:
  - Hold cfg_valid high for 4 cycles: exactly 2 writes accepted, and cfg_ready alternates 1,0,1,0.
  - With NUM_CH=3, write cfg_ch=3: cfg_err pulses once, and all led and state are unchanged.
- Collision: time a BLINK rewrite of ch2 (period=2) so acceptance lands on a tick edge.
  - ph_cnt=0 and led[2]=1; the next toggle comes after 2 full ticks.
  - ch0, also in BLINK, advances on that same tick.
- Reset mid-run: assert rst_n low asynchronously while ch0 is in PWM and ch1 in BLINK.
  - led goes to 0 before the next clk edge.
  - After release, all channels are OFF until rewritten.
